// File: rtl/fir_output_stage_if.sv
// Output stream of the FIR output stage: signed sample with valid/ready handshake.
interface fir_output_stage_if #(
  parameter int BW_out = 8
);
  logic signed [BW_out-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/fir_output_stage.sv
// FIR output stage: optional decimation, round/shift/saturate to BW_out,
// then a small FIFO draining over valid/ready, with sticky saturation/overflow flags.
module fir_output_stage #(
  parameter int BW_sum = 15,
  parameter int BW_out = 8,
  parameter int SHIFT  = 4,
  parameter int DECIM  = 1,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [BW_sum-1:0]  sum_in,
  input  logic                      sum_valid,
  input  logic                      clear_flags,
  fir_output_stage_if.master        out_bus,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      sat_flag,
  output logic                      overflow
);

  localparam int EXT_W = BW_sum + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  // 2**SHIFT/2 is the half-LSB rounding constant, and collapses to 0 when SHIFT=0
  localparam logic signed [EXT_W-1:0] RND   = EXT_W'(2 ** SHIFT / 2);
  localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'(2 ** (BW_out - 1) - 1);
  localparam logic signed [EXT_W-1:0] MIN_V = EXT_W'(-(2 ** (BW_out - 1)));

  function automatic logic signed [EXT_W-1:0] round_shift(input logic signed [BW_sum-1:0] x);
    logic signed [EXT_W-1:0] t;
    t = EXT_W'(x);
    t = t + RND;
    return t >>> SHIFT;
  endfunction

  function automatic logic is_clipped(input logic signed [EXT_W-1:0] r);
    return (r > MAX_V) || (r < MIN_V);
  endfunction

  function automatic logic signed [BW_out-1:0] saturate(input logic signed [EXT_W-1:0] r);
    if (r > MAX_V) return MAX_V[BW_out-1:0];
    if (r < MIN_V) return MIN_V[BW_out-1:0];
    return r[BW_out-1:0];
  endfunction

  // ---- stage 0: decimation select and rounding/saturation ----
  logic [CNT_W-1:0]         decim_cnt;
  logic                     vld_p0;
  logic signed [EXT_W-1:0]  rnd_p0;
  logic signed [BW_out-1:0] data_p0;
  logic                     clip_p0;

  assign vld_p0  = sum_valid && (decim_cnt == '0);
  assign rnd_p0  = round_shift(sum_in);
  assign data_p0 = saturate(rnd_p0);
  assign clip_p0 = is_clipped(rnd_p0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      decim_cnt <= '0;
    end else if (sum_valid) begin
      decim_cnt <= (decim_cnt == CNT_W'(DECIM - 1)) ? '0 : decim_cnt + CNT_W'(1);
    end
  end

  // ---- stage 1: registered kept sample ----
  logic                     vld_p1;
  logic signed [BW_out-1:0] data_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_p1 <= 1'b0;
    else        vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (vld_p0) data_p1 <= data_p0;
  end

  // ---- stage 2: FIFO write and handshake drain ----
  logic signed [BW_out-1:0] mem [DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [LVL_W-1:0]         count;
  logic                     pop, push, drop;

  assign pop  = (count != '0) && out_bus.out_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle
  assign push = vld_p1 && ((count < LVL_W'(DEPTH)) || pop);
  assign drop = vld_p1 && !push;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_p1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + LVL_W'(push) - LVL_W'(pop);
    end
  end

  // Set events take priority over a simultaneous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_flag <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (vld_p0 && clip_p0) sat_flag <= 1'b1;
      else if (clear_flags)  sat_flag <= 1'b0;
      if (drop)              overflow <= 1'b1;
      else if (clear_flags)  overflow <= 1'b0;
    end
  end

  assign out_bus.out_valid = (count != '0);
  assign out_bus.out_data  = (count != '0) ? mem[rd_ptr] : '0;
  assign fifo_level        = count;

endmodule

// File: tb/tb_fir_output_stage.sv
// Bench for fir_output_stage: directed scenarios plus random traffic against a queue-based model.
module tb_fir_output_stage;
  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic signed [14:0] sum_a = '0, sum_b = '0;
  logic vld_a = 1'b0, vld_b = 1'b0, clr_a = 1'b0, clr_b = 1'b0;
  logic [LVL_W-1:0] lvl_a, lvl_b;
  logic sat_a, sat_b, ovf_a, ovf_b;

  fir_output_stage_if #(.BW_out(8)) bus_a ();
  fir_output_stage_if #(.BW_out(8)) bus_b ();

  fir_output_stage #(.BW_sum(15), .BW_out(8), .SHIFT(4), .DECIM(1), .DEPTH(DEPTH)) dut_a (
    .clk(clk), .reset(reset), .sum_in(sum_a), .sum_valid(vld_a), .clear_flags(clr_a),
    .out_bus(bus_a), .fifo_level(lvl_a), .sat_flag(sat_a), .overflow(ovf_a));

  fir_output_stage #(.BW_sum(15), .BW_out(8), .SHIFT(4), .DECIM(3), .DEPTH(DEPTH)) dut_b (
    .clk(clk), .reset(reset), .sum_in(sum_b), .sum_valid(vld_b), .clear_flags(clr_b),
    .out_bus(bus_b), .fifo_level(lvl_b), .sat_flag(sat_b), .overflow(ovf_b));

  int errors = 0;
  int checks = 0;

  // Reference: real-valued floor division for rounding, queue for the FIFO
  function automatic int ref_round(int x);
    return $rtoi($floor((real'(x) + 8.0) / 16.0));
  endfunction

  function automatic int ref_value(int x);
    int r;
    r = ref_round(x);
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  int m_q[$];
  bit m_pv, m_sat, m_ovf, m_pop, m_push, m_sev, m_oev;
  int m_pval;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_pv = 1'b0; m_pval = 0; m_sat = 1'b0; m_ovf = 1'b0;
    end else begin
      m_pop  = (m_q.size() > 0) && (bus_a.out_ready === 1'b1);
      m_push = m_pv && ((m_q.size() < DEPTH) || m_pop);
      m_oev  = m_pv && !m_push;
      m_sev  = vld_a && (ref_round(int'(sum_a)) > 127 || ref_round(int'(sum_a)) < -128);
      m_sat  = m_sev || (m_sat && !clr_a);
      m_ovf  = m_oev || (m_ovf && !clr_a);
      if (m_pop) void'(m_q.pop_front());
      if (m_push) m_q.push_back(m_pval);
      m_pv   = vld_a;
      m_pval = ref_value(int'(sum_a));
    end
  end

  task automatic test_reset();
    bus_a.out_ready = 1'b0; bus_b.out_ready = 1'b0; reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus_a.out_valid); end
    checks++; if (bus_a.out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus_a.out_data); end
    checks++; if (lvl_a !== '0) begin errors++; $display("FAIL reset_level: got %0d want 0", lvl_a); end
    checks++; if (sat_a !== 1'b0 || ovf_a !== 1'b0) begin errors++; $display("FAIL reset_flags: got sat=%b ovf=%b want 0 0", sat_a, ovf_a); end
    checks++; if (bus_b.out_valid !== 1'b0 || lvl_b !== '0) begin errors++; $display("FAIL reset_b: got valid=%b level=%0d want 0 0", bus_b.out_valid, lvl_b); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rounding();
    int rin[5]  = '{56, -24, -8, 7, 8};
    int rexp[5] = '{4, -1, 0, 0, 1};
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 2 && i < 7) begin
        checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 8'(rexp[i-2])) begin
          errors++; $display("FAIL round_%0d: got valid=%b data=%0d want 1 %0d", i - 2, bus_a.out_valid, bus_a.out_data, rexp[i-2]);
        end
      end
      if (i < 5) begin vld_a = 1'b1; sum_a = 15'(rin[i]); end
      else vld_a = 1'b0;
    end
    checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL round_drain: got valid=%b want 0", bus_a.out_valid); end
    checks++; if (sat_a !== 1'b0) begin errors++; $display("FAIL round_sat: got %b want 0", sat_a); end
  endtask

  task automatic test_saturation();
    bus_a.out_ready = 1'b1;
    @(negedge clk); vld_a = 1'b1; sum_a = 15'h3FFF;
    @(negedge clk);
    checks++; if (sat_a !== 1'b1) begin errors++; $display("FAIL sat_set: got %b want 1", sat_a); end
    sum_a = 15'h4000;
    @(negedge clk);
    checks++; if (bus_a.out_data !== 8'h7F) begin errors++; $display("FAIL sat_pos: got %h want 7f", bus_a.out_data); end
    vld_a = 1'b0; clr_a = 1'b1;
    @(negedge clk);
    checks++; if (bus_a.out_data !== 8'h80) begin errors++; $display("FAIL sat_neg: got %h want 80", bus_a.out_data); end
    checks++; if (sat_a !== 1'b0) begin errors++; $display("FAIL sat_clear: got %b want 0", sat_a); end
    vld_a = 1'b1; sum_a = 15'h3FFF;
    @(negedge clk);
    checks++; if (sat_a !== 1'b1) begin errors++; $display("FAIL sat_set_wins: got %b want 1", sat_a); end
    vld_a = 1'b0; clr_a = 1'b0;
    @(negedge clk);
    checks++; if (bus_a.out_data !== 8'h7F) begin errors++; $display("FAIL sat_pos2: got %h want 7f", bus_a.out_data); end
    repeat (2) @(negedge clk);
    clr_a = 1'b1; @(negedge clk); clr_a = 1'b0;
  endtask

  task automatic test_overflow();
    bus_a.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); vld_a = 1'b1; sum_a = 15'(16 * (k + 1));
    end
    @(negedge clk); vld_a = 1'b0;
    checks++; if (bus_a.out_data !== 8'd1) begin errors++; $display("FAIL ovf_hold: got %0d want 1", bus_a.out_data); end
    @(negedge clk);
    checks++; if (lvl_a !== LVL_W'(4)) begin errors++; $display("FAIL ovf_level: got %0d want 4", lvl_a); end
    checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", ovf_a); end
    checks++; if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 8'd1) begin errors++; $display("FAIL ovf_head: got valid=%b data=%0d want 1 1", bus_a.out_valid, bus_a.out_data); end
    bus_a.out_ready = 1'b1;
    for (int j = 1; j < 4; j++) begin
      @(negedge clk);
      checks++; if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 8'(j + 1)) begin errors++; $display("FAIL ovf_pop_%0d: got valid=%b data=%0d want 1 %0d", j, bus_a.out_valid, bus_a.out_data, j + 1); end
    end
    @(negedge clk);
    checks++; if (bus_a.out_valid !== 1'b0 || lvl_a !== '0) begin errors++; $display("FAIL ovf_empty: got valid=%b level=%0d want 0 0", bus_a.out_valid, lvl_a); end
    clr_a = 1'b1; @(negedge clk); clr_a = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k >= 6) begin
        checks++;
        if (lvl_a !== LVL_W'(4) || ovf_a !== 1'b0 || bus_a.out_data !== 8'(k - 4)) begin
          errors++; $display("FAIL b2b_%0d: got level=%0d ovf=%b data=%0d want 4 0 %0d", k, lvl_a, ovf_a, bus_a.out_data, k - 4);
        end
      end
      if (k < 13) begin vld_a = 1'b1; sum_a = 15'(16 * (k + 1)); end
      else vld_a = 1'b0;
      bus_a.out_ready = (k >= 5);
    end
    bus_a.out_ready = 1'b1;
    repeat (7) @(negedge clk);
  endtask

  task automatic test_decimation();
    int got[$];
    int k = 0;
    int dexp[3] = '{1, 4, 7};
    bus_b.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_b.out_valid === 1'b1) got.push_back(int'(bus_b.out_data));
      if (k < 9 && (c % 3) != 2) begin vld_b = 1'b1; sum_b = 15'(16 * (k + 1)); k++; end
      else vld_b = 1'b0;
    end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL decim_count: got %0d want 3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got.size() || got[i] != dexp[i]) begin errors++; $display("FAIL decim_%0d: got %0d want %0d", i, (i < got.size()) ? got[i] : -999, dexp[i]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_d;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      exp_d = (m_q.size() > 0) ? 8'(m_q[0]) : 8'h00;
      checks++; if (bus_a.out_data !== exp_d) begin errors++; $display("FAIL rnd_data@%0d: got %h want %h", c, bus_a.out_data, exp_d); end
      checks++; if (bus_a.out_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", c, bus_a.out_valid, m_q.size() > 0); end
      checks++; if (lvl_a !== LVL_W'(m_q.size())) begin errors++; $display("FAIL rnd_level@%0d: got %0d want %0d", c, lvl_a, m_q.size()); end
      checks++; if (sat_a !== m_sat || ovf_a !== m_ovf) begin errors++; $display("FAIL rnd_flags@%0d: got sat=%b ovf=%b want %b %b", c, sat_a, ovf_a, m_sat, m_ovf); end
      vld_a = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) != 0) sum_a = 15'($urandom_range(0, 32767));
      else sum_a = 15'(int'($urandom_range(0, 4095)) - 2048);
      bus_a.out_ready = ($urandom_range(0, 2) != 0);
      clr_a = ($urandom_range(0, 15) == 0);
    end
    vld_a = 1'b0; clr_a = 1'b0;
  endtask

  task automatic test_async_reset();
    bus_a.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    clr_a = 1'b1; @(negedge clk); clr_a = 1'b0;
    bus_a.out_ready = 1'b0;
    vld_a = 1'b1; sum_a = 15'h3FFF;
    @(negedge clk); sum_a = 15'd32;
    @(negedge clk); sum_a = 15'd48;
    @(negedge clk); vld_a = 1'b0;
    @(negedge clk);
    checks++; if (lvl_a !== LVL_W'(3) || sat_a !== 1'b1) begin errors++; $display("FAIL arst_pre: got level=%0d sat=%b want 3 1", lvl_a, sat_a); end
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    checks++; if (bus_a.out_valid !== 1'b0 || lvl_a !== '0) begin errors++; $display("FAIL arst_fifo: got valid=%b level=%0d want 0 0", bus_a.out_valid, lvl_a); end
    checks++; if (bus_a.out_data !== 8'h00) begin errors++; $display("FAIL arst_data: got %h want 00", bus_a.out_data); end
    checks++; if (sat_a !== 1'b0 || ovf_a !== 1'b0) begin errors++; $display("FAIL arst_flags: got sat=%b ovf=%b want 0 0", sat_a, ovf_a); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); vld_a = 1'b1; sum_a = 15'd64; bus_a.out_ready = 1'b1;
    @(negedge clk); vld_a = 1'b0;
    checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL arst_lat1: got valid=%b want 0", bus_a.out_valid); end
    @(negedge clk);
    checks++; if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 8'd4) begin errors++; $display("FAIL arst_lat2: got valid=%b data=%0d want 1 4", bus_a.out_valid, bus_a.out_data); end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_overflow();
    test_back_to_back();
    test_decimation();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fir_output_stage.md
Name: fir_output_stage

Overview:
Downstream stage of the 7-tap FIR. It consumes the FIR's full-precision signed accumulator sum and optionally decimates the sample stream. Each kept sample is rounded, shifted and saturated to the 8-bit output width, then buffered in a small FIFO. The FIFO drains over a valid/ready handshake toward the pin mux, and the block reports sticky saturation and overflow flags.

Parameters:
BW_sum, 15, width of signed input sum
BW_out, 8, width of signed output sample
SHIFT, 4, arithmetic right shift applied before saturation (0..BW_sum-1)
DECIM, 1, keep one of every DECIM valid inputs (1..16)
DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset; clears all state immediately
sum_in  input  BW_sum  signed FIR sum, two's complement
sum_valid  input  1  sum_in is a new sample this cycle
clear_flags  input  1  synchronous clear of sat_flag and overflow
out_data  output  BW_out  signed sample at FIFO head
out_valid  output  1  FIFO not empty
out_ready  input  1  consumer accepts out_data this cycle
fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy
sat_flag  output  1  sticky: a kept sample was clipped
overflow  output  1  sticky: a processed sample was dropped, FIFO full

Behaviour:
- Reset (reset=0, asynchronous): decim counter=0, stage-1 valid=0, FIFO empty, out_valid=0, out_data=0, fifo_level=0, sat_flag=0, overflow=0. Takes effect mid-operation; in-flight and buffered samples are discarded.
- Decimation: counter runs 0..DECIM-1, advancing only on sum_valid and wrapping to 0. A sample is kept when sum_valid=1 and counter==0. With DECIM=1, every valid sample is kept.
- Arithmetic: all arithmetic is signed at width BW_sum+1.
  - If SHIFT>0: r = (sum_in + 2^(SHIFT-1)) >>> SHIFT, i.e. round half toward +inf. If SHIFT=0: r = sum_in.
  - Saturate r to [-2^(BW_out-1), 2^(BW_out-1)-1]. If clipping occurred on a kept sample, sat_flag <= 1.
- Stage 1: the rounded and saturated value and its valid bit are registered on the edge where the sample is kept.
- Stage 2: on the next edge, if stage-1 valid, the value is written to the FIFO tail.
- Latency: kept at edge E0 -> out_valid=1 after E1 when the FIFO was empty. Throughput is one sample per clock.
- FIFO is a circular buffer with read/write pointers plus a count.
  - out_data is the head entry, combinational from storage. out_data=0 when empty.
  - Pop when out_valid && out_ready.
  - Write when stage-1 valid && (level<DEPTH || pop this cycle).
  - Simultaneous push and pop: level is unchanged, and a full FIFO accepts the write.
  - Full with no pop: the stage-1 sample is dropped, overflow <= 1, FIFO contents are unchanged.
  - out_ready while empty: no effect, pointers are unchanged.
  - Pointers wrap modulo DEPTH.
- Flags: clear_flags=1 clears both flags at the edge. If a set event occurs in the same cycle, set wins.
- sum_in is ignored when sum_valid=0. out_data is stable while out_valid=1 and out_ready=0.

Test Plan:
- Rounding (SHIFT=4, DECIM=1, out_ready=1): sum_in 56 -> 4; -24 -> -1 (0xFF); -8 -> 0; 7 -> 0; 8 -> 1. Each appears on out_data 2 edges after its sum_valid; sat_flag stays 0.
- Saturation: sum_in 16383 -> 127 (0x7F), sat_flag=1. sum_in -16384 -> -128 (0x80). clear_flags pulse -> sat_flag=0 next edge. clear_flags together with a clipping sample -> sat_flag stays 1.
- FIFO full/overflow (DEPTH=4, out_ready=0): push 6 samples 16,32,48,64,80,96 (-> 1..6). Then fifo_level=4, overflow=1. Raising out_ready pops 1,2,3,4 in order, then out_valid=0.
- Simultaneous push/pop at full: keep level=4 with out_ready=1 and sum_valid=1 every cycle -> no drop, overflow stays 0, output order is preserved.
- Decimation (DECIM=3): 9 consecutive valid inputs 16..144 step 16 -> outputs 1,4,7 only. Idle cycles with sum_valid=0 do not advance the counter.
- Async reset mid-stream: with 3 entries buffered, assert reset=0 between clock edges -> out_valid, fifo_level, flags and out_data read 0 immediately, with no clock edge required. After release, the first kept sample appears again after 2 edges.
